// File: rtl/if_prefetch.sv
// Instruction-fetch stage: PC generation, synchronous ROM request and a DEPTH-entry prefetch queue.
// A redirect flushes the queue and discards the ROM read that is still in flight.
module if_prefetch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     IMEM_AW  = 6,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       redirect_i,
  input  logic [PC_W-1:0]            redirect_pc_i,
  output logic                       imem_req_o,
  output logic [IMEM_AW-1:0]         imem_addr_o,
  input  logic [31:0]                imem_rdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [31:0]                out_inst_o,
  output logic [PC_W-1:0]            out_pc_o,
  output logic [PC_W-1:0]            out_pc4_o,
  output logic                       if_flush_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int unsigned     PTR_W      = $clog2(DEPTH);
  localparam int unsigned     LVL_W      = $clog2(DEPTH+1);
  localparam logic [LVL_W:0]  DEPTH_C    = (LVL_W+1)'(DEPTH);
  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(3));

  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic             inflight_q, inflight_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      hold_inst_q, hold_inst_d;
  logic [PC_W-1:0]  hold_pc_q, hold_pc_d;

  logic [31:0]      inst_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q   [DEPTH];

  logic             not_empty;
  logic             pop;
  logic             push;
  logic             issue;
  logic [LVL_W:0]   occupancy;
  logic [31:0]      head_inst;
  logic [PC_W-1:0]  head_pc;

  // Credit check counts the in-flight read so a push can never overflow the queue.
  always_comb begin
    not_empty = (level_q != '0);
    head_inst = inst_mem_q[rd_ptr_q];
    head_pc   = pc_mem_q[rd_ptr_q];
    pop       = not_empty & out_ready_i & ~redirect_i;
    push      = inflight_q & ~redirect_i;
    occupancy = {1'b0, level_q} + (LVL_W+1)'(inflight_q) - (LVL_W+1)'(pop);
    issue     = reset_i & ~redirect_i & (occupancy < DEPTH_C);
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    req_pc_d    = req_pc_q;
    inflight_d  = issue;
    level_d     = level_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    hold_inst_d = hold_inst_q;
    hold_pc_d   = hold_pc_q;
    if (not_empty) begin
      hold_inst_d = head_inst;
      hold_pc_d   = head_pc;
    end
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & ALIGN_MASK;
      level_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (issue) begin
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      fetch_pc_q  <= RESET_PC;
      req_pc_q    <= '0;
      inflight_q  <= 1'b0;
      level_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      hold_inst_q <= '0;
      hold_pc_q   <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      req_pc_q    <= req_pc_d;
      inflight_q  <= inflight_d;
      level_q     <= level_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      hold_inst_q <= hold_inst_d;
      hold_pc_q   <= hold_pc_d;
    end
  end

  // Queue storage needs no reset: only entries covered by level_q are ever shown.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= imem_rdata_i;
      pc_mem_q[wr_ptr_q]   <= req_pc_q;
    end
  end

  always_comb begin
    imem_req_o  = issue;
    imem_addr_o = fetch_pc_q[IMEM_AW+1:2];
    out_valid_o = not_empty;
    out_inst_o  = not_empty ? head_inst : hold_inst_q;
    out_pc_o    = not_empty ? head_pc : hold_pc_q;
    out_pc4_o   = out_pc_o + PC_STEP;
    if_flush_o  = redirect_i;
    level_o     = level_q;
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: directed scenarios plus random traffic against a queue-based reference model.
module tb_if_prefetch;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_ready;

  logic        a_req, a_valid, a_flush;
  logic [5:0]  a_addr;
  logic [31:0] a_rdata, a_inst, a_pc, a_pc4;
  logic [2:0]  a_level;

  logic        b_req, b_valid, b_flush;
  logic [5:0]  b_addr;
  logic [31:0] b_rdata, b_inst, b_pc, b_pc4;
  logic [2:0]  b_level;

  logic [31:0] rom [64];

  int checks = 0;
  int errors = 0;
  int b_k = -1;

  ent_t        mq[$];
  logic [31:0] m_fetch, m_req, m_last_pc, m_last_inst;
  bit          m_infl;

  if_prefetch #(.PC_W(32), .IMEM_AW(6), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut_a (
    .clk_i(clk), .reset_i(reset_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(a_req), .imem_addr_o(a_addr), .imem_rdata_i(a_rdata),
    .out_valid_o(a_valid), .out_ready_i(out_ready), .out_inst_o(a_inst),
    .out_pc_o(a_pc), .out_pc4_o(a_pc4), .if_flush_o(a_flush), .level_o(a_level)
  );

  if_prefetch #(.PC_W(32), .IMEM_AW(6), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_b (
    .clk_i(clk), .reset_i(reset_n), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_rdata_i(b_rdata),
    .out_valid_o(b_valid), .out_ready_i(out_ready), .out_inst_o(b_inst),
    .out_pc_o(b_pc), .out_pc4_o(b_pc4), .if_flush_o(b_flush), .level_o(b_level)
  );

  always @(posedge clk) begin
    if (a_req) a_rdata <= rom[a_addr];
    if (b_req) b_rdata <= rom[b_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_fetch     = 32'h0;
    m_req       = 32'h0;
    m_infl      = 1'b0;
    m_last_pc   = 32'h0;
    m_last_inst = 32'h0;
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic cyc(input bit rst_v, input bit rdy, input bit redir, input logic [31:0] rpc);
    int   pop;
    int   issue;
    ent_t shown;
    reset_n     = rst_v;
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(negedge clk);
    if (!reset_n) model_reset();
    if (mq.size() != 0) shown = mq[0];
    else                shown = {m_last_pc, m_last_inst};
    pop   = (reset_n && mq.size() != 0 && rdy && !redir) ? 1 : 0;
    issue = (reset_n && !redir && (mq.size() + int'(m_infl) - pop < DEPTH)) ? 1 : 0;

    chk("out_valid", a_valid, mq.size() != 0);
    chk("level", a_level, mq.size());
    chk("out_pc", a_pc, shown.pc);
    chk("out_inst", a_inst, shown.inst);
    chk("out_pc4", a_pc4, shown.pc + 32'd4);
    chk("imem_req", a_req, issue);
    if (issue != 0) chk("imem_addr", a_addr, m_fetch[7:2]);
    chk("if_flush", a_flush, redir);

    if (b_k >= 0 && b_k < 6) begin
      case (b_k)
        0: begin chk("b_req0", b_req, 1); chk("b_addr0", b_addr, 6'h3E); end
        1: chk("b_addr1", b_addr, 6'h3F);
        2: begin chk("b_addr2", b_addr, 6'h00); chk("b_pc2", b_pc, 32'hFFFF_FFF8);
                 chk("b_inst2", b_inst, 32'h1000_003E); end
        3: begin chk("b_pc3", b_pc, 32'hFFFF_FFFC); chk("b_inst3", b_inst, 32'h1000_003F); end
        4: begin chk("b_pc4_pc", b_pc, 32'h0); chk("b_pc4_pc4", b_pc4, 32'h4);
                 chk("b_inst4", b_inst, 32'h1000_0000); end
        default: chk("b_valid5", b_valid, 1);
      endcase
      b_k++;
    end

    if (reset_n) begin
      m_last_pc   = shown.pc;
      m_last_inst = shown.inst;
      if (redir) begin
        mq.delete();
        m_fetch = rpc & ~32'd3;
        m_infl  = 1'b0;
      end else begin
        if (pop != 0) void'(mq.pop_front());
        if (m_infl) mq.push_back({m_req, rom[m_req[7:2]]});
        m_infl = (issue != 0);
        if (issue != 0) begin
          m_req   = m_fetch;
          m_fetch = m_fetch + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    int r;
    for (int i = 0; i < 64; i++) rom[i] = 32'h1000_0000 + i;
    a_rdata = '0;
    b_rdata = '0;
    model_reset();

    // Reset state, then streaming with ID always ready
    repeat (3) cyc(0, 1, 0, 32'h0);
    chk("b_rst_pc4", b_pc4, 32'h4);
    b_k = 0;
    repeat (14) cyc(1, 1, 0, 32'h0);

    // ID stall from reset: queue saturates, then drains in order
    repeat (2) cyc(0, 0, 0, 32'h0);
    repeat (10) cyc(1, 0, 0, 32'h0);
    chk("t2_level_sat", a_level, 4);
    repeat (10) cyc(1, 1, 0, 32'h0);

    // Redirect with level 3
    cnt = 0;
    while (mq.size() != 3 && cnt < 20) begin
      cyc(1, 0, 0, 32'h0);
      cnt++;
    end
    chk("t3_reach_level3", a_level, 3);
    cyc(1, 1, 1, 32'h23);
    chk("t3_level_zero", a_level, 0);
    repeat (8) cyc(1, 1, 0, 32'h0);

    // Back-to-back redirects
    cyc(1, 1, 1, 32'h40);
    cyc(1, 1, 1, 32'h80);
    repeat (8) cyc(1, 1, 0, 32'h0);

    // Reset while level 2 with a read in flight
    cyc(1, 0, 1, 32'h100);
    cnt = 0;
    while (!(mq.size() == 2 && m_infl) && cnt < 20) begin
      cyc(1, 0, 0, 32'h0);
      cnt++;
    end
    chk("t6_level2_inflight", {a_level, 1'b0}, {3'd2, 1'b0});
    cyc(0, 0, 0, 32'h0);
    chk("t6_valid_low", a_valid, 0);
    repeat (6) cyc(1, 1, 0, 32'h0);

    // Random traffic
    repeat (400) begin
      r = $urandom_range(0, 99);
      cyc(r != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
